// File: rtl/cpu_defs.sv
// Shared pipeline encodings: writeback source select, load types, halt marker.
// Also used by the ID and EX stages.
package cpu_defs;

   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'd0,
      WB_SEL_LOAD = 2'd1,
      WB_SEL_PC4  = 2'd2,
      WB_SEL_ZERO = 2'd3
   } wb_sel_e;

   // Codes 3, 6 and 7 are unassigned and fall back to a full-word load.
   typedef enum logic [2:0] {
      LD_B  = 3'd0,
      LD_H  = 3'd1,
      LD_W  = 3'd2,
      LD_BU = 3'd4,
      LD_HU = 3'd5
   } ld_type_e;

   localparam logic [31:0] HALT_INST_DEF = 32'h8000_0000;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Byte/halfword lane selection and sign/zero extension of a data-memory word.
// This block is purely combinational.
module load_extend
   import cpu_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rdata,
   input  logic [1:0]       off,
   input  logic [2:0]       ld_type,
   output logic [WIDTH-1:0] ld_val
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   function automatic logic [WIDTH-1:0] sext8(input logic [7:0] b);
      return {{(WIDTH-8){b[7]}}, b};
   endfunction

   function automatic logic [WIDTH-1:0] zext8(input logic [7:0] b);
      return {{(WIDTH-8){1'b0}}, b};
   endfunction

   function automatic logic [WIDTH-1:0] sext16(input logic [15:0] h);
      return {{(WIDTH-16){h[15]}}, h};
   endfunction

   function automatic logic [WIDTH-1:0] zext16(input logic [15:0] h);
      return {{(WIDTH-16){1'b0}}, h};
   endfunction

   // Halfword lane uses off[1] only; a misaligned half reads its enclosing half.
   always_comb begin
      lane_b = rdata[{off, 3'b000} +: 8];
      lane_h = rdata[{off[1], 4'b0000} +: 16];
      case (ld_type)
         LD_B:    ld_val = sext8(lane_b);
         LD_BU:   ld_val = zext8(lane_b);
         LD_H:    ld_val = sext16(lane_h);
         LD_HU:   ld_val = zext16(lane_h);
         default: ld_val = rdata;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB segment register with writeback source selection, register file
// write port, and commit/halt/retire-count reporting.
module mem_wb_stage
   import cpu_defs::*;
#(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH_B   = 5,
   parameter logic [WIDTH-1:0] HALT_INST = HALT_INST_DEF
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               stall,
   input  logic               flush,
   input  logic               mem_valid,
   input  logic [WIDTH-1:0]   mem_pc,
   input  logic [WIDTH-1:0]   mem_inst,
   input  logic [WIDTH-1:0]   mem_alu_res,
   input  logic [WIDTH-1:0]   mem_dmem_rdata,
   input  logic               mem_rf_we,
   input  logic [DEPTH_B-1:0] mem_rf_wa,
   input  logic [1:0]         mem_wb_sel,
   input  logic [2:0]         mem_ld_type,
   output logic               rf_we,
   output logic [DEPTH_B-1:0] rf_wa,
   output logic [WIDTH-1:0]   rf_wd,
   output logic               commit,
   output logic [WIDTH-1:0]   commit_pc,
   output logic [WIDTH-1:0]   commit_inst,
   output logic               commit_halt,
   output logic               halted,
   output logic [31:0]        commit_count
);

   logic               vld_p1;
   logic [WIDTH-1:0]   pc_p1;
   logic [WIDTH-1:0]   inst_p1;
   logic [WIDTH-1:0]   alu_res_p1;
   logic [WIDTH-1:0]   rdata_p1;
   logic               rf_we_p1;
   logic [DEPTH_B-1:0] rf_wa_p1;
   logic [1:0]         wb_sel_p1;
   logic [2:0]         ld_type_p1;

   logic               committed;
   logic               halted_q;
   logic [31:0]        count_q;
   logic [WIDTH-1:0]   ld_val;

   // MEM -> WB boundary
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_p1     <= 1'b0;
         pc_p1      <= '0;
         inst_p1    <= '0;
         alu_res_p1 <= '0;
         rdata_p1   <= '0;
         rf_we_p1   <= 1'b0;
         rf_wa_p1   <= '0;
         wb_sel_p1  <= '0;
         ld_type_p1 <= '0;
      end else if (flush) begin
         vld_p1     <= 1'b0;
         pc_p1      <= '0;
         inst_p1    <= '0;
         alu_res_p1 <= '0;
         rdata_p1   <= '0;
         rf_we_p1   <= 1'b0;
         rf_wa_p1   <= '0;
         wb_sel_p1  <= '0;
         ld_type_p1 <= '0;
      end else if (!stall) begin
         vld_p1     <= mem_valid;
         pc_p1      <= mem_pc;
         inst_p1    <= mem_inst;
         alu_res_p1 <= mem_alu_res;
         rdata_p1   <= mem_dmem_rdata;
         rf_we_p1   <= mem_rf_we;
         rf_wa_p1   <= mem_rf_wa;
         wb_sel_p1  <= mem_wb_sel;
         ld_type_p1 <= mem_ld_type;
      end
   end

   // committed marks a stalled entry that has already retired so it is not
   // reported or counted again while it sits in the register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         committed <= 1'b0;
         halted_q  <= 1'b0;
         count_q   <= '0;
      end else begin
         if (flush || !stall)
            committed <= 1'b0;
         else if (commit)
            committed <= 1'b1;
         if (commit_halt)
            halted_q <= 1'b1;
         if (commit)
            count_q <= count_q + 32'd1;
      end
   end

   load_extend #(
      .WIDTH (WIDTH)
   ) u_load_extend (
      .rdata   (rdata_p1),
      .off     (alu_res_p1[1:0]),
      .ld_type (ld_type_p1),
      .ld_val  (ld_val)
   );

   always_comb begin
      case (wb_sel_p1)
         WB_SEL_ALU:  rf_wd = alu_res_p1;
         WB_SEL_LOAD: rf_wd = ld_val;
         WB_SEL_PC4:  rf_wd = pc_p1 + WIDTH'(4);
         default:     rf_wd = '0;
      endcase
   end

   assign rf_we        = vld_p1 & rf_we_p1 & (rf_wa_p1 != '0) & ~halted_q;
   assign rf_wa        = rf_wa_p1;
   assign commit       = vld_p1 & ~halted_q & ~committed;
   assign commit_pc    = pc_p1;
   assign commit_inst  = inst_p1;
   assign commit_halt  = commit & (inst_p1 == HALT_INST);
   assign halted       = halted_q;
   assign commit_count = count_q;

endmodule
